// File: rtl/os_dram_arb.sv
// Round-robin arbiter that shares the DRAM bridge between the buyer and seller record engines.
// A one-entry write-through record cache lets repeat reads of the same User_id skip the bridge.
module os_dram_arb (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [1:0]       req_rwb,
   input  logic [1:0][7:0]  req_id,
   input  logic [1:0][63:0] req_wdata,
   input  logic             flush,
   output logic [1:0]       req_done,
   output logic [63:0]      rsp_data,
   output logic             busy,
   output logic             C_in_valid,
   output logic             C_r_wb,
   output logic [7:0]       C_addr,
   output logic [63:0]      C_data_w,
   input  logic             C_out_valid,
   input  logic [63:0]      C_data_r
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic        rwb;
      logic [7:0]  id;
      logic [63:0] wdata;
   } req_t;

   state_t      state, state_nx;
   req_t        cur, cur_nx, sel;
   logic        gnt, gnt_nx, g_sel;
   logic        rr_ptr, rr_nx;
   logic        cache_valid, cv_nx;
   logic [7:0]  cache_tag, ct_nx;
   logic [63:0] cache_data, cd_nx;
   logic [63:0] rsp_nx, cdw_nx;
   logic [1:0]  done_nx;
   logic        civ_nx, crwb_nx, hit;
   logic [7:0]  caddr_nx;

   // Round-robin pointer only decides ties; a lone requester always wins.
   assign g_sel = (&req_valid) ? rr_ptr : req_valid[1];

   always_comb begin
      sel.rwb   = req_rwb[g_sel];
      sel.id    = req_id[g_sel];
      sel.wdata = req_wdata[g_sel];
   end

   assign hit = sel.rwb && cache_valid && (cache_tag == sel.id);

   always_comb begin
      state_nx = state;
      cur_nx   = cur;
      gnt_nx   = gnt;
      rr_nx    = rr_ptr;
      cv_nx    = cache_valid;
      ct_nx    = cache_tag;
      cd_nx    = cache_data;
      rsp_nx   = rsp_data;
      done_nx  = 2'b00;
      civ_nx   = 1'b0;
      crwb_nx  = C_r_wb;
      caddr_nx = C_addr;
      cdw_nx   = C_data_w;
      unique case (state)
         S_IDLE: begin
            if (flush) begin
               cv_nx = 1'b0;
            end else if (|req_valid) begin
               gnt_nx = g_sel;
               cur_nx = sel;
               if (hit) begin
                  rsp_nx         = cache_data;
                  done_nx[g_sel] = 1'b1;
                  state_nx       = S_DONE;
               end else begin
                  // Bridge fields are registered here so they are stable during ISSUE.
                  civ_nx   = 1'b1;
                  crwb_nx  = sel.rwb;
                  caddr_nx = sel.id;
                  cdw_nx   = sel.wdata;
                  state_nx = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT: begin
            if (C_out_valid) begin
               if (cur.rwb) begin
                  rsp_nx = C_data_r;
                  cd_nx  = C_data_r;
               end else begin
                  cd_nx  = cur.wdata;
               end
               ct_nx        = cur.id;
               cv_nx        = 1'b1;
               done_nx[gnt] = 1'b1;
               state_nx     = S_DONE;
            end
         end
         S_DONE: begin
            rr_nx    = ~gnt;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cur         <= '0;
         gnt         <= 1'b0;
         rr_ptr      <= 1'b0;
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_data  <= '0;
         rsp_data    <= '0;
         req_done    <= '0;
         busy        <= 1'b0;
         C_in_valid  <= 1'b0;
         C_r_wb      <= 1'b0;
         C_addr      <= '0;
         C_data_w    <= '0;
      end else begin
         state       <= state_nx;
         cur         <= cur_nx;
         gnt         <= gnt_nx;
         rr_ptr      <= rr_nx;
         cache_valid <= cv_nx;
         cache_tag   <= ct_nx;
         cache_data  <= cd_nx;
         rsp_data    <= rsp_nx;
         req_done    <= done_nx;
         busy        <= (state_nx != S_IDLE);
         C_in_valid  <= civ_nx;
         C_r_wb      <= crwb_nx;
         C_addr      <= caddr_nx;
         C_data_w    <= cdw_nx;
      end
   end

endmodule

// File: tb/tb_os_dram_arb.sv
// Bench for os_dram_arb: directed vector table, reset-in-WAIT sequence and randomized rounds
// checked against a transaction-level model of the arbiter, cache and bridge memory.
module tb_os_dram_arb;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [1:0]       req_valid, req_rwb;
   logic [1:0][7:0]  req_id;
   logic [1:0][63:0] req_wdata;
   logic             flush;
   logic [1:0]       req_done;
   logic [63:0]      rsp_data;
   logic             busy, C_in_valid, C_r_wb;
   logic [7:0]       C_addr;
   logic [63:0]      C_data_w;
   logic             C_out_valid;
   logic [63:0]      C_data_r;

   os_dram_arb dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rwb(req_rwb), .req_id(req_id),
      .req_wdata(req_wdata), .flush(flush), .req_done(req_done), .rsp_data(rsp_data),
      .busy(busy), .C_in_valid(C_in_valid), .C_r_wb(C_r_wb), .C_addr(C_addr),
      .C_data_w(C_data_w), .C_out_valid(C_out_valid), .C_data_r(C_data_r)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_fail = 0;

   // Model state: bridge memory, cache tag/valid and tie-break pointer.
   logic [63:0] mem [256];
   bit          m_valid;
   logic [7:0]  m_tag;
   int          rr_m;

   typedef struct {
      logic [1:0]  mask;
      logic [1:0]  rwb;
      logic [7:0]  id0, id1;
      logic [63:0] wd0, wd1;
      bit          fl;
      int          lat;
      int          exp_g;
      bit          exp_hit;
      logic [63:0] exp_rsp;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_done"}, {62'd0, req_done}, 64'd0);
      chk({tag, "_rsp_data"}, rsp_data, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
      chk({tag, "_c_in_valid"}, {63'd0, C_in_valid}, 64'd0);
      chk({tag, "_c_r_wb"}, {63'd0, C_r_wb}, 64'd0);
      chk({tag, "_c_addr"}, {56'd0, C_addr}, 64'd0);
      chk({tag, "_c_data_w"}, C_data_w, 64'd0);
   endtask

   // Presents up to two requests and services them to completion, acting as both requesters
   // and the bridge. Called and returns #1 after a rising edge with the DUT idle.
   task automatic run_round(input logic [1:0] mask, input logic [1:0] rwb,
                            input logic [7:0] id0, input logic [7:0] id1,
                            input logic [63:0] wd0, input logic [63:0] wd1,
                            input bit fl, input int lat,
                            output int first_g, output bit first_hit, output logic [63:0] first_rsp);
      logic [1:0] pend;
      int start, cd, iss_cyc, g_exp, ndone;
      bit issued, hit_exp;
      first_g = -1; first_hit = 0; first_rsp = '0;
      req_rwb = rwb; req_id[0] = id0; req_id[1] = id1;
      req_wdata[0] = wd0; req_wdata[1] = wd1;
      req_valid = mask; flush = fl;
      pend = mask;
      start = fl ? cyc + 1 : cyc;
      if (fl) m_valid = 0;
      cd = 0; issued = 0; iss_cyc = 0; ndone = 0;
      for (int k = 0; k < 200 && pend != 2'b00; k++) begin
         @(posedge clk); #1;
         flush = 1'b0;
         C_out_valid = 1'b0;
         g_exp = (pend == 2'b11) ? rr_m : (pend[1] ? 1 : 0);
         hit_exp = req_rwb[g_exp] && m_valid && (m_tag == req_id[g_exp]);
         if (C_in_valid) begin
            chk("bridge_only_on_miss", {63'd0, hit_exp}, 64'd0);
            chk("issue_cycle", cyc, start + 1);
            chk("c_addr", {56'd0, C_addr}, {56'd0, req_id[g_exp]});
            chk("c_r_wb", {63'd0, C_r_wb}, {63'd0, req_rwb[g_exp]});
            if (!req_rwb[g_exp]) chk("c_data_w", C_data_w, req_wdata[g_exp]);
            issued = 1; iss_cyc = cyc; cd = lat;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               C_out_valid = 1'b1;
               if (req_rwb[g_exp]) C_data_r = mem[req_id[g_exp]];
               else begin
                  C_data_r = {$urandom, $urandom};
                  mem[req_id[g_exp]] = req_wdata[g_exp];
               end
            end
         end
         if (req_done != 2'b00) begin
            chk("req_done_grant", {62'd0, req_done}, (g_exp == 1) ? 64'd2 : 64'd1);
            chk("bridge_used", {63'd0, issued}, {63'd0, !hit_exp});
            chk("done_cycle", cyc, hit_exp ? start + 1 : iss_cyc + lat + 1);
            if (req_rwb[g_exp]) chk("rsp_data", rsp_data, mem[req_id[g_exp]]);
            if (ndone == 0) begin
               first_g = g_exp; first_hit = hit_exp; first_rsp = rsp_data;
            end
            m_valid = 1; m_tag = req_id[g_exp]; rr_m = 1 - g_exp;
            pend[g_exp] = 1'b0; req_valid[g_exp] = 1'b0;
            start = cyc + 1; issued = 0; ndone++;
         end
      end
      chk("round_complete", {62'd0, pend}, 64'd0);
      req_valid = 2'b00; flush = 1'b0; C_out_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_after_round", {63'd0, busy}, 64'd0);
   endtask

   int          fg;
   bit          fh;
   logic [63:0] fr;
   bit          seen_bad;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
      mem[3] = 64'h3333_0000_3333_0003;
      mem[5] = 64'hDEAD_BEEF_0123_4567;
      m_valid = 0; m_tag = '0; rr_m = 0;

      //        mask   rwb    id0    id1    wd0                     wd1    fl lat g hit rsp
      tbl[0] = '{2'b11, 2'b01, 8'd3,  8'd9,  64'h0,                  64'h1, 0, 2, 0, 0, 64'h3333_0000_3333_0003};
      tbl[1] = '{2'b01, 2'b01, 8'd9,  8'd0,  64'h0,                  64'h0, 0, 1, 0, 1, 64'h1};
      tbl[2] = '{2'b01, 2'b01, 8'd5,  8'd0,  64'h0,                  64'h0, 0, 3, 0, 0, 64'hDEAD_BEEF_0123_4567};
      tbl[3] = '{2'b01, 2'b01, 8'd5,  8'd0,  64'h0,                  64'h0, 0, 1, 0, 1, 64'hDEAD_BEEF_0123_4567};
      tbl[4] = '{2'b01, 2'b01, 8'd5,  8'd0,  64'h0,                  64'h0, 1, 2, 0, 0, 64'hDEAD_BEEF_0123_4567};
      tbl[5] = '{2'b11, 2'b10, 8'd7,  8'd5,  64'hCAFE_F00D_0000_0007, 64'h0, 0, 2, 1, 1, 64'hDEAD_BEEF_0123_4567};
      tbl[6] = '{2'b11, 2'b11, 8'd200, 8'd7, 64'h0,                  64'h0, 0, 4, 1, 1, 64'hCAFE_F00D_0000_0007};

      rst_n = 1'b0; req_valid = '0; req_rwb = '0; req_id = '0; req_wdata = '0;
      flush = 1'b0; C_out_valid = 1'b0; C_data_r = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 7; v++) begin
         run_round(tbl[v].mask, tbl[v].rwb, tbl[v].id0, tbl[v].id1, tbl[v].wd0, tbl[v].wd1,
                   tbl[v].fl, tbl[v].lat, fg, fh, fr);
         chk($sformatf("vec%0d_first_grant", v), fg, tbl[v].exp_g);
         chk($sformatf("vec%0d_first_hit", v), {63'd0, fh}, {63'd0, tbl[v].exp_hit});
         chk($sformatf("vec%0d_first_rsp", v), fr, tbl[v].exp_rsp);
      end

      // Reset while WAITing on a write to the cached id must drop the cache entry.
      run_round(2'b01, 2'b01, 8'd5, 8'd0, 64'h0, 64'h0, 0, 1, fg, fh, fr);
      req_id[0] = 8'd5; req_rwb = 2'b00; req_wdata[0] = 64'h5555_AAAA_5555_AAAA; req_valid = 2'b01;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (C_in_valid) break;
      end
      chk("rst_test_issue", {63'd0, C_in_valid}, 64'd1);
      @(posedge clk); #1;
      chk("rst_test_busy_in_wait", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      req_valid = 2'b00;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_valid = 0; rr_m = 0;
      @(posedge clk); #1;
      C_out_valid = 1'b1; C_data_r = 64'hBAD0_BAD0_BAD0_BAD0;
      seen_bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         C_out_valid = 1'b0;
         if (req_done != 2'b00 || busy) seen_bad = 1;
      end
      chk("stale_completion_ignored", {63'd0, seen_bad}, 64'd0);
      run_round(2'b01, 2'b01, 8'd5, 8'd0, 64'h0, 64'h0, 0, 2, fg, fh, fr);
      chk("post_reset_read_is_miss", {63'd0, fh}, 64'd0);
      chk("post_reset_rsp", fr, 64'hDEAD_BEEF_0123_4567);

      for (int r = 0; r < 60; r++) begin
         run_round(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom_range(0, 3)),
                   8'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0), $urandom_range(1, 4), fg, fh, fr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
